// File: rtl/tx_fsrc_invalid_insert.sv
// TX FSRC rate matcher: pulls upstream samples on transport requests and replaces
// whole frames with the NP-dependent invalid-sample pattern as the phase accumulator carries.
module tx_fsrc_invalid_insert #(
  parameter int DATA_WIDTH  = 1024,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic                   tx_glblclk,
  input  logic                   tx_transport_resetn_gc,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   tx_sample_req,
  output logic [DATA_WIDTH-1:0]  tx_sample_data,
  output logic                   tx_sample_valid,
  input  logic [7:0]             np_param,
  input  logic [7:0]             fsrc_frame_cnt_max,
  input  logic [ACCUM_WIDTH-1:0] fsrc_accum_add,
  input  logic                   fsrc_en,
  output logic                   fsrc_underflow,
  input  logic                   fsrc_underflow_clr,
  output logic [31:0]            fsrc_invalid_frame_cnt
);

  // One NP-bit field is a 1 in its MSB; only complete fields are placed, so leftover MSBs stay 0.
  function automatic logic [DATA_WIDTH-1:0] make_pattern(input int np);
    logic [DATA_WIDTH-1:0] pat;
    pat = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pat[i] = ((i % np) == (np - 1));
    end
    return pat;
  endfunction

  localparam logic [DATA_WIDTH-1:0] PAT_NP8  = make_pattern(8);
  localparam logic [DATA_WIDTH-1:0] PAT_NP12 = make_pattern(12);
  localparam logic [DATA_WIDTH-1:0] PAT_NP16 = make_pattern(16);

  logic [ACCUM_WIDTH-1:0] accum_r;
  logic [7:0]             frame_cnt_r;
  logic                   frame_invalid_r;
  logic [ACCUM_WIDTH:0]   sum_s;
  logic                   word0_s;
  logic                   slot_invalid_s;
  logic                   underflow_set_s;
  logic [DATA_WIDTH-1:0]  pattern_s;

  // Slot classification; word 0 uses the fresh decision so it applies to the whole frame.
  always_comb begin
    sum_s          = {1'b0, accum_r} + {1'b0, fsrc_accum_add};
    word0_s        = (frame_cnt_r == 8'd0);
    slot_invalid_s = 1'b0;
    if (word0_s) begin
      slot_invalid_s = sum_s[ACCUM_WIDTH] & fsrc_en;
    end else begin
      slot_invalid_s = frame_invalid_r;
    end
    case (np_param)
      8'd11:   pattern_s = PAT_NP12;
      8'd15:   pattern_s = PAT_NP16;
      default: pattern_s = PAT_NP8;
    endcase
    s_ready         = tx_sample_req & ~slot_invalid_s;
    underflow_set_s = s_ready & ~s_valid;
  end

  // Frame position, per-frame decision and phase accumulator.
  always_ff @(posedge tx_glblclk) begin
    if (!tx_transport_resetn_gc) begin
      accum_r         <= '0;
      frame_cnt_r     <= 8'd0;
      frame_invalid_r <= 1'b0;
    end else if (tx_sample_req) begin
      // >= keeps the counter bounded if max is lowered mid-frame
      if (frame_cnt_r >= fsrc_frame_cnt_max) begin
        frame_cnt_r <= 8'd0;
      end else begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (word0_s) begin
        frame_invalid_r <= slot_invalid_s;
        if (fsrc_en) begin
          accum_r <= sum_s[ACCUM_WIDTH-1:0];
        end else begin
          accum_r <= accum_r;
        end
      end else begin
        frame_invalid_r <= frame_invalid_r;
        accum_r         <= accum_r;
      end
    end else begin
      frame_cnt_r     <= frame_cnt_r;
      frame_invalid_r <= frame_invalid_r;
      accum_r         <= accum_r;
    end
  end

  // Transport response: one-cycle request-to-data latency.
  always_ff @(posedge tx_glblclk) begin
    if (!tx_transport_resetn_gc) begin
      tx_sample_data  <= '0;
      tx_sample_valid <= 1'b0;
    end else begin
      tx_sample_valid <= tx_sample_req;
      if (tx_sample_req) begin
        if (s_ready && s_valid) begin
          tx_sample_data <= s_data;
        end else begin
          tx_sample_data <= pattern_s;
        end
      end else begin
        tx_sample_data <= tx_sample_data;
      end
    end
  end

  // Status: sticky underflow (a new set beats clear) and saturating invalid-frame count.
  always_ff @(posedge tx_glblclk) begin
    if (!tx_transport_resetn_gc) begin
      fsrc_underflow         <= 1'b0;
      fsrc_invalid_frame_cnt <= 32'd0;
    end else begin
      fsrc_underflow <= underflow_set_s | (fsrc_underflow & ~fsrc_underflow_clr);
      if (tx_sample_req && word0_s && slot_invalid_s &&
          (fsrc_invalid_frame_cnt != 32'hFFFF_FFFF)) begin
        fsrc_invalid_frame_cnt <= fsrc_invalid_frame_cnt + 32'd1;
      end else begin
        fsrc_invalid_frame_cnt <= fsrc_invalid_frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_tx_fsrc_invalid_insert.sv
// Bench for tx_fsrc_invalid_insert: vector tables per scenario, expected words queued at
// request time and compared when the DUT answers one cycle later.
module tb_tx_fsrc_invalid_insert;
  localparam int DW = 1024;

  localparam logic [DW-1:0] P8  = {128{8'h80}};
  localparam logic [DW-1:0] P12 = {4'h0, {85{12'h800}}};
  localparam logic [DW-1:0] P16 = {64{16'h8000}};

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          req;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [7:0]    np_param;
  logic [7:0]    cnt_max;
  logic [31:0]   accum_add;
  logic          fsrc_en;
  logic          underflow;
  logic          underflow_clr;
  logic [31:0]   inv_cnt;

  always #5 clk = ~clk;

  tx_fsrc_invalid_insert #(.DATA_WIDTH(DW), .ACCUM_WIDTH(32)) dut (
    .tx_glblclk             (clk),
    .tx_transport_resetn_gc (resetn),
    .s_data                 (s_data),
    .s_valid                (s_valid),
    .s_ready                (s_ready),
    .tx_sample_req          (req),
    .tx_sample_data         (tx_data),
    .tx_sample_valid        (tx_valid),
    .np_param               (np_param),
    .fsrc_frame_cnt_max     (cnt_max),
    .fsrc_accum_add         (accum_add),
    .fsrc_en                (fsrc_en),
    .fsrc_underflow         (underflow),
    .fsrc_underflow_clr     (underflow_clr),
    .fsrc_invalid_frame_cnt (inv_cnt)
  );

  // inv: expected word is the invalid pattern; rdy: expected s_ready
  typedef struct {
    logic req;
    logic sv;
    logic en;
    logic clr;
    logic inv;
    logic rdy;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [DW-1:0] pat_for(input logic [7:0] np);
    case (np)
      8'd11:   return P12;
      8'd15:   return P16;
      default: return P8;
    endcase
  endfunction

  task automatic chk1(input string name, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual %0b required %0b", name, act, want);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, want);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual top/low %h/%h required top/low %h/%h", name,
               act[DW-1:DW-64], act[63:0], want[DW-1:DW-64], want[63:0]);
    end
  endtask

  task automatic add_vec(input logic r, input logic sv, input logic en, input logic clr,
                         input logic inv, input logic rdy);
    vec_t v;
    v.req = r; v.sv = sv; v.en = en; v.clr = clr; v.inv = inv; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    req           = v.req;
    s_valid       = v.sv;
    fsrc_en       = v.en;
    underflow_clr = v.clr;
    for (int w = 0; w < DW / 32; w++) s_data[w*32 +: 32] = $urandom();
    if (v.req) exp_q.push_back(v.inv ? pat_for(np_param) : s_data);
    #1;
    chk1("s_ready", s_ready, v.rdy);
    @(posedge clk);
    #1;
    chk1("tx_sample_valid", tx_valid, v.req);
    if (exp_q.size() > 0) chkw("tx_sample_data", tx_data, exp_q.pop_front());
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) step(vecs[i]);
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req = 1'b0; underflow_clr = 1'b0; fsrc_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; s_valid = 1'b0; s_data = '0;
    np_param = 8'd15; cnt_max = 8'd3; accum_add = 32'd0;
    fsrc_en = 1'b0; underflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset tx_sample_valid", tx_valid, 1'b0);
    chkw("reset tx_sample_data", tx_data, '0);
    chk1("reset fsrc_underflow", underflow, 1'b0);
    chk32("reset invalid_frame_cnt", inv_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // ratio 1/4: frames 1-3 data, frame 4 invalid
    accum_add = 32'h4000_0000;
    for (int i = 0; i < 16; i++) add_vec(1'b1, 1'b1, 1'b1, 1'b0, i >= 12, i < 12);
    run_vecs();
    chk32("ratio invalid_frame_cnt", inv_cnt, 32'd1);
    chk1("ratio underflow", underflow, 1'b0);

    // pass-through with insertion disabled, including idle request cycles
    do_reset();
    accum_add = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) add_vec((i % 3) != 2, 1'b1, 1'b0, 1'b0, 1'b0, (i % 3) != 2);
    run_vecs();
    chk32("passthru invalid_frame_cnt", inv_cnt, 32'd0);
    chk1("passthru underflow", underflow, 1'b0);

    // patterns via underflowed data slots
    np_param = 8'd11; add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_vecs();
    chk1("underflow set", underflow, 1'b1);
    np_param = 8'd7;  add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_vecs();
    np_param = 8'd3;  add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_vecs();
    np_param = 8'd15; add_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run_vecs();
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); run_vecs();
    chk1("underflow clr", underflow, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); run_vecs();
    chk1("underflow stays clear", underflow, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); run_vecs();
    chk1("underflow set beats clr", underflow, 1'b1);

    // enable raised at frame_cnt=2 takes effect at the next word 0; alternate thereafter
    do_reset();
    accum_add = 32'h8000_0000;
    for (int i = 0; i < 20; i++) begin
      add_vec(1'b1, 1'b1, i >= 2, 1'b0, (i >= 8 && i < 12) || i >= 16,
              !((i >= 8 && i < 12) || i >= 16));
    end
    run_vecs();
    chk32("enable invalid_frame_cnt", inv_cnt, 32'd2);

    // advance to frame_cnt=2 (accum becomes 0x8000_0000), with an underflow, then reset
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_vecs();
    chk1("pre-reset underflow", underflow, 1'b1);
    @(negedge clk);
    resetn = 1'b0; req = 1'b1; s_valid = 1'b1;
    @(posedge clk);
    #1;
    chk1("midreset tx_sample_valid", tx_valid, 1'b0);
    chkw("midreset tx_sample_data", tx_data, '0);
    chk1("midreset underflow", underflow, 1'b0);
    chk32("midreset invalid_frame_cnt", inv_cnt, 32'd0);
    @(negedge clk);
    resetn = 1'b1; req = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) add_vec(1'b1, 1'b1, 1'b1, 1'b0, i >= 4, i < 4);
    run_vecs();
    chk32("post-reset invalid_frame_cnt", inv_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_fsrc_invalid_insert.md
Name: tx_fsrc_invalid_insert

Overview:
- TX-side counterpart of the RX FSRC valid-gating logic: rate-matches an upstream sample stream to the JESD TX transport by inserting whole frames of FSRC invalid-sample words.
- A fractional accumulator decides, at each frame boundary, whether the next frame carries upstream data or the invalid pattern.
- Sits between the TX sample source (AXI-stream-like, valid/ready) and the TX transport sample interface, which is request/pull driven. One instance per link.

Parameters:
- DATA_WIDTH, 1024, sample bus width in bits (multiple of 8).
- ACCUM_WIDTH, 32, width of the FSRC phase accumulator and increment.

Ports:
- tx_glblclk  input  1  link global clock; all logic on rising edge.
- tx_transport_resetn_gc  input  1  synchronous, active-low reset.
- s_data  input  DATA_WIDTH  upstream sample word.
- s_valid  input  1  upstream word available.
- s_ready  output  1  upstream word consumed this cycle (combinational).
- tx_sample_req  input  1  transport requests one word this cycle.
- tx_sample_data  output  DATA_WIDTH  registered word to transport.
- tx_sample_valid  output  1  tx_sample_data is valid; registered response to the request of the previous cycle.
- np_param  input  8  NP-1 (7, 11 or 15); selects the invalid pattern.
- fsrc_frame_cnt_max  input  8  words per frame minus 1.
- fsrc_accum_add  input  ACCUM_WIDTH  per-frame accumulator increment; the fraction of invalid frames is add/2^ACCUM_WIDTH.
- fsrc_en  input  1  enables invalid-frame insertion.
- fsrc_underflow  output  1  sticky flag: upstream was empty in a data slot.
- fsrc_underflow_clr  input  1  clears fsrc_underflow.
- fsrc_invalid_frame_cnt  output  32  count of inserted invalid frames; saturates at 0xFFFF_FFFF.

Behaviour:
- Reset (resetn=0 on clock edge): the following clear to 0: accum, frame_cnt, frame_invalid, tx_sample_data, tx_sample_valid, fsrc_underflow, fsrc_invalid_frame_cnt. The enable-pending register is set to 0. Reset mid-frame abandons the frame; the next request starts a new frame at frame_cnt=0.
- Invalid pattern per NP:
  - NP = np_param+1, limited to 8/12/16; any other np_param value maps to NP=8.
  - Each NP-bit field is 1 followed by NP-1 zeros (e.g. NP=16 gives 0x8000).
  - Fields are replicated floor(DATA_WIDTH/NP) times from bit 0 upward; leftover MSBs are 0.
  - Precompute the three patterns as constants.
- Frame counter: advances only on a cycle with tx_sample_req=1.
  - frame_cnt >= fsrc_frame_cnt_max → wraps to 0; otherwise increments.
  - The >= comparison makes a runtime decrease of max safe.
- Frame decision: made on a request cycle with frame_cnt==0.
  - {carry, accum} <= accum + fsrc_accum_add.
  - frame_invalid <= carry & fsrc_en.
  - The decision applies to every word of that frame, including word 0.
  - When fsrc_en=0, accum holds its value and frame_invalid=0.
- fsrc_en rising: takes effect only at the next frame_cnt==0 decision, never mid-frame. Accum is not cleared.
- Data slot (request, frame not invalid):
  - s_ready=1.
  - If s_valid=1: tx_sample_data <= s_data.
  - If s_valid=0: tx_sample_data <= invalid pattern and fsrc_underflow is set.
- Invalid slot: s_ready=0; tx_sample_data <= invalid pattern.
- s_ready is 0 whenever tx_sample_req=0.
- tx_sample_valid <= tx_sample_req. Latency is exactly 1 cycle, request to data. Back-to-back requests are supported every cycle.
- fsrc_invalid_frame_cnt increments once per invalid frame, at the frame's word 0.
- Underflow flag: clear has priority over a simultaneous set only when no new underflow occurs in that cycle. Set wins on the same cycle.
- np_param and fsrc_frame_cnt_max are quasi-static; changes take effect on the next request without glitch protection.
- Target size: ~150–250 lines of RTL.

Test Plan:
- Ratio check: add=0x4000_0000, max=3, fsrc_en=1, s_valid=1, continuous requests → frames 1–3 carry data, frame 4 all 0x8000 (np=15), repeating; invalid_frame_cnt=1 after 16 words.
- Pass-through: fsrc_en=0, add=0xFFFF_FFFF → every word equals s_data one cycle after its request; s_ready mirrors tx_sample_req; counter stays 0.
- Patterns:
  - np=11 → 85 fields of 0x800, bits [1023:1020]=0.
  - np=7 → 0x80 in every byte.
  - np=3 → treated as NP=8 (0x80 in every byte).
- Underflow: s_valid=0 during a data slot → invalid pattern output and fsrc_underflow=1. Then pulse clr with no underflow → flag 0. Then clr coincident with a new underflow → flag stays 1.
- Enable timing: assert fsrc_en at frame_cnt=2 with add=0x8000_0000 → no insertion in the current frame; the first decision occurs at the next word 0 and invalid frames alternate thereafter.
- Reset mid-frame: resetn=0 at frame_cnt=2 → all outputs 0 next cycle; after release, the first request takes decision at frame_cnt=0 with accum=0.
